seq_stage_controller: RTL and testbench

Multi-cycle sequencer for the Y86-64 sequential core. Owns the architectural PC and processor status, and steps the fetch, decode, execute, memory and writeback blocks through one-hot stage enables. Handshakes data-memory accesses, computes the next PC, and stops the core on halt or on an exception.

---
 rtl/seq_stage_controller_if.sv | 37 +++
 rtl/seq_stage_controller.sv | 160 ++++++++++++++++
 tb/tb_seq_stage_controller.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_stage_controller_if.sv
// Handshake and datapath bundle between the Y86-64 sequencer and the
// fetch/decode/execute/memory/writeback blocks.
// master: the sequencer. slave: the datapath side (or a testbench).
interface seq_stage_controller_if #(
  parameter int CNT_W = 32
);
  // From fetch / execute / data memory
  logic [3:0]       icode;
  logic             instr_valid;
  logic             imem_error;
  logic             cnd;
  logic [63:0]      valC;
  logic [63:0]      valP;
  logic [63:0]      valM;
  logic             mem_ack;
  logic             dmem_error;
  logic             step;
  // From the sequencer
  logic [63:0]      pc;
  logic [4:0]       stage_en;
  logic             mem_req;
  logic [2:0]       stat;
  logic             halted;
  logic [CNT_W-1:0] retired;

  modport master (
    input  icode, instr_valid, imem_error, cnd, valC, valP, valM,
           mem_ack, dmem_error, step,
    output pc, stage_en, mem_req, stat, halted, retired
  );

  modport slave (
    output icode, instr_valid, imem_error, cnd, valC, valP, valM,
           mem_ack, dmem_error, step,
    input  pc, stage_en, mem_req, stat, halted, retired
  );
endinterface

// File: rtl/seq_stage_controller.sv
// Multi-cycle sequencer for the Y86-64 sequential core.
// Owns PC, status and the retired-instruction counter; walks the stages
// with one-hot enables, handshakes data memory with a bounded wait, and
// stops the core on halt or fault.
// Optional build macro: SINGLE_STEP_EN -- adds a STALL state after each
// PC update that is released by a pulse on step.
module seq_stage_controller #(
  parameter logic [63:0] START_PC    = 64'd0,
  parameter int          MEM_TIMEOUT = 16,
  parameter int          CNT_W       = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  seq_stage_controller_if.master bus
);

  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  // Count value seen in the last MEMORY cycle that may still accept an ack
  localparam logic [TW-1:0] TO_LAST = TW'(MEM_TIMEOUT - 1);

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_PCUPD     = 3'd5,
    S_HALTED    = 3'd6,
    S_STALL     = 3'd7
  } state_t;

  // Stage whose enable bit sits at each position of stage_en
  localparam state_t STAGE_STATE [5] = '{S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK};

  state_t           state_reg,   state_next;
  logic [63:0]      pc_reg,      pc_next;
  logic [2:0]       stat_reg,    stat_next;
  logic [CNT_W-1:0] retired_reg, retired_next;
  logic [TW-1:0]    mem_cnt_reg, mem_cnt_next;

  logic             is_mem;
  logic             step_in;
  logic [4:0]       stage_en_w;

  // Instructions that touch data memory: rmmovq, mrmovq, call, ret, pushq, popq
  assign is_mem = bus.icode inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};

`ifdef SINGLE_STEP_EN
  assign step_in = bus.step;
`else
  // Without single-step the input has no effect
  logic step_unused;
  assign step_unused = bus.step;
  assign step_in     = 1'b0;
`endif

  // State and architectural registers; reset wins over every state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= S_FETCH;
      pc_reg      <= START_PC;
      stat_reg    <= STAT_AOK;
      retired_reg <= '0;
      mem_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      stat_reg    <= stat_next;
      retired_reg <= retired_next;
      mem_cnt_reg <= mem_cnt_next;
    end
  end

  // Next-state, next-PC, status and memory wait counting
  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    stat_next    = stat_reg;
    retired_next = retired_reg;
    mem_cnt_next = '0;
    case (state_reg)
      S_FETCH: begin
        if (bus.imem_error) begin
          stat_next  = STAT_ADR;
          state_next = S_HALTED;
        end else if (!bus.instr_valid) begin
          stat_next  = STAT_INS;
          state_next = S_HALTED;
        end else if (bus.icode == 4'h0) begin
          stat_next  = STAT_HLT;
          state_next = S_HALTED;
        end else begin
          state_next = S_DECODE;
        end
      end
      S_DECODE:  state_next = S_EXECUTE;
      S_EXECUTE: state_next = S_MEMORY;
      S_MEMORY: begin
        if (!is_mem) begin
          state_next = S_WRITEBACK;
        end else if (bus.mem_ack) begin
          if (bus.dmem_error) begin
            stat_next  = STAT_ADR;
            state_next = S_HALTED;
          end else begin
            state_next = S_WRITEBACK;
          end
        end else if (mem_cnt_reg == TO_LAST) begin
          // Ran out of wait budget without an ack
          stat_next  = STAT_ADR;
          state_next = S_HALTED;
        end else begin
          mem_cnt_next = mem_cnt_reg + TW'(1);
        end
      end
      S_WRITEBACK: state_next = S_PCUPD;
      S_PCUPD: begin
        case (bus.icode)
          4'h8:    pc_next = bus.valC;
          4'h7:    pc_next = bus.cnd ? bus.valC : bus.valP;
          4'h9:    pc_next = bus.valM;
          default: pc_next = bus.valP;
        endcase
        retired_next = retired_reg + CNT_W'(1);
`ifdef SINGLE_STEP_EN
        state_next = S_STALL;
`else
        state_next = S_FETCH;
`endif
      end
      S_STALL: begin
        if (step_in) begin
          state_next = S_FETCH;
        end
      end
      S_HALTED: state_next = S_HALTED;
      default:  state_next = S_FETCH;
    endcase
  end

  // One enable per datapath stage, active only in its own state
  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_stage_en
      assign stage_en_w[gi] = (state_reg == STAGE_STATE[gi]);
    end
  endgenerate

  assign bus.stage_en = stage_en_w;
  assign bus.mem_req  = (state_reg == S_MEMORY) && is_mem;
  assign bus.pc       = pc_reg;
  assign bus.stat     = stat_reg;
  assign bus.halted   = (state_reg == S_HALTED);
  assign bus.retired  = retired_reg;

endmodule

// File: tb/tb_seq_stage_controller.sv
// Testbench for seq_stage_controller: table of directed instructions,
// hand-written fault/reset sequences and a randomized instruction stream
// checked against an instruction-level reference model.
module tb_seq_stage_controller;

  localparam logic [63:0] START_PC    = 64'h100;
  localparam int          MEM_TIMEOUT = 16;
  localparam int          CNT_W       = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seq_stage_controller_if #(.CNT_W(CNT_W)) bus ();

  seq_stage_controller #(
    .START_PC(START_PC),
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  icode;
    logic        cnd;
    logic        valid;
    logic        imem_err;
    logic        dmem_err;
    int          ack_delay;
    logic [63:0] valc;
    logic [63:0] valp;
    logic [63:0] valm;
  } instr_t;

  typedef struct {
    instr_t      in;
    logic [63:0] exp_pc;
    logic [2:0]  exp_stat;
    int          exp_cycles;
  } vec_t;

  // Reference model state
  logic [63:0] m_pc;
  logic [31:0] m_ret;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- instruction-level reference model ----------------
  function automatic bit is_mem_icode(input logic [3:0] ic);
    return (ic == 4'h4) || (ic == 4'h5) || (ic == 4'h8) || (ic == 4'h9) ||
           (ic == 4'hA) || (ic == 4'hB);
  endfunction

  function automatic bit fetch_fault(input instr_t t);
    return t.imem_err || !t.valid || (t.icode == 4'h0);
  endfunction

  function automatic int mem_cycles(input instr_t t);
    if (!is_mem_icode(t.icode)) return 1;
    if (t.ack_delay >= MEM_TIMEOUT) return MEM_TIMEOUT;
    return t.ack_delay + 1;
  endfunction

  function automatic bit mem_fault(input instr_t t);
    return is_mem_icode(t.icode) && ((t.ack_delay >= MEM_TIMEOUT) || t.dmem_err);
  endfunction

  function automatic int total_cycles(input instr_t t);
    if (fetch_fault(t)) return 1;
    return 3 + mem_cycles(t) + (mem_fault(t) ? 0 : 2);
  endfunction

  function automatic logic [4:0] exp_stage(input instr_t t, input int c);
    int mc;
    mc = mem_cycles(t);
    if (c == 0) return 5'b00001;
    if (c == 1) return 5'b00010;
    if (c == 2) return 5'b00100;
    if (c < 3 + mc) return 5'b01000;
    if (c == 3 + mc) return 5'b10000;
    return 5'b00000;
  endfunction

  function automatic logic [2:0] exp_stat_of(input instr_t t);
    if (t.imem_err) return 3'd3;
    if (!t.valid) return 3'd4;
    if (t.icode == 4'h0) return 3'd2;
    if (mem_fault(t)) return 3'd3;
    return 3'd1;
  endfunction

  function automatic logic [63:0] next_pc(input instr_t t, input logic [63:0] cur);
    if (exp_stat_of(t) != 3'd1) return cur;
    if (t.icode == 4'h8) return t.valc;
    if (t.icode == 4'h7 && t.cnd) return t.valc;
    if (t.icode == 4'h9) return t.valm;
    return t.valp;
  endfunction

  function automatic instr_t mk(input logic [3:0] ic, input logic cnd, input logic [63:0] valc,
                                input logic [63:0] valp, input logic [63:0] valm,
                                input int ack, input logic dmem);
    instr_t t;
    t.icode = ic; t.cnd = cnd; t.valid = 1'b1; t.imem_err = 1'b0; t.dmem_err = dmem;
    t.ack_delay = ack; t.valc = valc; t.valp = valp; t.valm = valm;
    return t;
  endfunction

  function automatic vec_t mkv(input instr_t t, input logic [63:0] epc, input logic [2:0] est,
                               input int ecyc);
    vec_t v;
    v.in = t; v.exp_pc = epc; v.exp_stat = est; v.exp_cycles = ecyc;
    return v;
  endfunction

  // ---------------- drivers ----------------
  task automatic do_reset();
    reset = 1'b1;
    bus.mem_ack = 1'b0; bus.dmem_error = 1'b0; bus.step = 1'b0;
    tick();
    reset = 1'b0;
    m_pc  = START_PC;
    m_ret = '0;
    chk("reset_pc", bus.pc, START_PC);
    chk("reset_stage_en", bus.stage_en, 5'b00001);
    chk("reset_stat", bus.stat, 3'd1);
    chk("reset_halted", bus.halted, 1'b0);
    chk("reset_retired", bus.retired, 0);
    chk("reset_mem_req", bus.mem_req, 1'b0);
    $display("txn reset pc=0x%0h stat=%0d", bus.pc, bus.stat);
  endtask

  // Runs one instruction starting in FETCH; checks each cycle's enables and
  // mem_req, then the architectural state at the end.
  task automatic run_instr(input string tag, input instr_t t, input logic [63:0] exp_pc,
                           input logic [2:0] exp_stat, input int ncyc, input logic [31:0] exp_ret);
    bit memi;
    logic [4:0] es;
    memi = is_mem_icode(t.icode);
    bus.icode = t.icode; bus.cnd = t.cnd; bus.instr_valid = t.valid;
    bus.imem_error = t.imem_err; bus.valC = t.valc; bus.valP = t.valp; bus.valM = t.valm;
    for (int c = 0; c < ncyc; c++) begin
      es = exp_stage(t, c);
      if (memi && es == 5'b01000) begin
        bus.mem_ack    = ((c - 3) == t.ack_delay);
        bus.dmem_error = bus.mem_ack ? t.dmem_err : 1'($urandom_range(0, 1));
      end else begin
        bus.mem_ack    = 1'($urandom_range(0, 1));
        bus.dmem_error = 1'($urandom_range(0, 1));
      end
      bus.step = 1'($urandom_range(0, 1));
      #1;
      chk({tag, "_stage_en"}, bus.stage_en, es);
      chk({tag, "_mem_req"}, bus.mem_req, memi && (es == 5'b01000));
      @(posedge clk);
      #1;
    end
    bus.mem_ack = 1'b0; bus.dmem_error = 1'b0; bus.step = 1'b0;
    #1;
    chk({tag, "_pc"}, bus.pc, exp_pc);
    chk({tag, "_stat"}, bus.stat, exp_stat);
    chk({tag, "_retired"}, bus.retired, exp_ret);
    chk({tag, "_halted"}, bus.halted, exp_stat != 3'd1);
    if (exp_stat == 3'd1) begin
`ifdef SINGLE_STEP_EN
      chk({tag, "_stall"}, bus.stage_en, 5'b00000);
      tick();
      tick();
      chk({tag, "_stall_hold"}, bus.stage_en, 5'b00000);
      chk({tag, "_stall_pc"}, bus.pc, exp_pc);
      bus.step = 1'b1;
      tick();
      bus.step = 1'b0;
`endif
      chk({tag, "_next_fetch"}, bus.stage_en, 5'b00001);
    end else begin
      chk({tag, "_halt_en"}, bus.stage_en, 5'b00000);
    end
    $display("txn %s icode=%0h cycles=%0d pc=0x%0h stat=%0d retired=%0d",
             tag, t.icode, ncyc, bus.pc, bus.stat, bus.retired);
  endtask

  // HALTED must ignore arbitrary inputs
  task automatic idle_check(input string tag, input logic [2:0] exp_stat, input logic [63:0] exp_pc,
                            input int n);
    for (int i = 0; i < n; i++) begin
      bus.icode = 4'($urandom_range(0, 15));
      bus.instr_valid = 1'($urandom_range(0, 1));
      bus.imem_error = 1'($urandom_range(0, 1));
      bus.mem_ack = 1'($urandom_range(0, 1));
      bus.dmem_error = 1'($urandom_range(0, 1));
      bus.step = 1'($urandom_range(0, 1));
      tick();
      chk({tag, "_idle_stat"}, bus.stat, exp_stat);
      chk({tag, "_idle_en"}, {bus.stage_en, bus.mem_req, bus.halted}, 7'b0000001);
    end
    chk({tag, "_idle_pc"}, bus.pc, exp_pc);
    bus.mem_ack = 1'b0; bus.dmem_error = 1'b0; bus.step = 1'b0;
    bus.instr_valid = 1'b1; bus.imem_error = 1'b0;
    $display("txn %s idle %0d cycles stat=%0d", tag, n, bus.stat);
  endtask

  // Runs one instruction through the model and the DUT, then recovers from halt
  task automatic model_run(input string tag, input instr_t t);
    logic [2:0]  st;
    logic [63:0] epc;
    st  = exp_stat_of(t);
    epc = next_pc(t, m_pc);
    if (st == 3'd1) m_ret = m_ret + 1;
    m_pc = epc;
    run_instr(tag, t, epc, st, total_cycles(t), m_ret);
    if (st != 3'd1) begin
      idle_check(tag, st, epc, 3);
      do_reset();
    end
  endtask

  vec_t   vecs [8];
  instr_t t;

  initial begin
    bus.icode = 4'h1; bus.instr_valid = 1'b1; bus.imem_error = 1'b0; bus.cnd = 1'b0;
    bus.valC = '0; bus.valP = '0; bus.valM = '0;
    bus.mem_ack = 1'b0; bus.dmem_error = 1'b0; bus.step = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    vecs[0] = mkv(mk(4'h1, 1'b0, 64'h0,   64'h101, 64'h0,  0, 1'b0), 64'h101, 3'd1, 6);
    vecs[1] = mkv(mk(4'h7, 1'b0, 64'h40,  64'h109, 64'h0,  0, 1'b0), 64'h109, 3'd1, 6);
    vecs[2] = mkv(mk(4'h7, 1'b1, 64'h40,  64'h109, 64'h0,  0, 1'b0), 64'h40,  3'd1, 6);
    vecs[3] = mkv(mk(4'h8, 1'b0, 64'h200, 64'h4A,  64'h0,  0, 1'b0), 64'h200, 3'd1, 6);
    vecs[4] = mkv(mk(4'h9, 1'b0, 64'h0,   64'h211, 64'h2A, 2, 1'b0), 64'h2A,  3'd1, 8);
    vecs[5] = mkv(mk(4'h4, 1'b0, 64'h0,   64'h34,  64'h0,  1, 1'b0), 64'h34,  3'd1, 7);
    vecs[6] = mkv(mk(4'h2, 1'b1, 64'h999, 64'h50,  64'h0,  0, 1'b0), 64'h50,  3'd1, 6);
    vecs[7] = mkv(mk(4'hB, 1'b0, 64'h0,   64'h60,  64'h0,  4, 1'b0), 64'h60,  3'd1, 10);

    do_reset();

    // Directed table
    for (int i = 0; i < 8; i++) begin
      run_instr($sformatf("vec%0d", i), vecs[i].in, vecs[i].exp_pc, vecs[i].exp_stat,
                vecs[i].exp_cycles, 32'(i + 1));
    end

    // rmmovq with data-memory fault: F,D,E,M then HALTED, no writeback
    run_instr("dmem_err", mk(4'h4, 1'b0, 64'h0, 64'h77, 64'h0, 0, 1'b1), 64'h60, 3'd3, 4, 32'd8);
    idle_check("dmem_err", 3'd3, 64'h60, 10);
    do_reset();

    // rmmovq never acked: ADR after MEM_TIMEOUT memory cycles
    run_instr("timeout", mk(4'h4, 1'b0, 64'h0, 64'h77, 64'h0, 1000, 1'b0), START_PC, 3'd3,
              3 + MEM_TIMEOUT, 32'd0);
    idle_check("timeout", 3'd3, START_PC, 10);
    do_reset();

    // Fetch faults with priority ADR > INS > HLT
    run_instr("halt", mk(4'h0, 1'b0, 64'h0, 64'h1, 64'h0, 0, 1'b0), START_PC, 3'd2, 1, 32'd0);
    idle_check("halt", 3'd2, START_PC, 10);
    do_reset();
    t = mk(4'h0, 1'b0, 64'h0, 64'h1, 64'h0, 0, 1'b0);
    t.valid = 1'b0;
    run_instr("ins", t, START_PC, 3'd4, 1, 32'd0);
    idle_check("ins", 3'd4, START_PC, 10);
    do_reset();
    t.imem_err = 1'b1;
    run_instr("adr", t, START_PC, 3'd3, 1, 32'd0);
    idle_check("adr", 3'd3, START_PC, 10);
    do_reset();

    // Reset while waiting in MEMORY with mem_req high
    bus.icode = 4'h5; bus.instr_valid = 1'b1; bus.imem_error = 1'b0; bus.valP = 64'h999;
    repeat (4) tick();
    chk("midmem_req_before", bus.mem_req, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midmem_req_after", bus.mem_req, 1'b0);
    chk("midmem_pc", bus.pc, START_PC);
    chk("midmem_stage_en", bus.stage_en, 5'b00001);
    $display("txn midmem_reset pc=0x%0h stage_en=%b", bus.pc, bus.stage_en);
    m_pc = START_PC; m_ret = '0;

    // Randomized stream against the reference model
    for (int n = 0; n < 300; n++) begin
      t.icode = 4'($urandom_range(0, 11));
      if (t.icode == 4'h0 && $urandom_range(0, 1) == 0) t.icode = 4'h1;
      t.cnd       = 1'($urandom_range(0, 1));
      t.valid     = ($urandom_range(0, 39) != 0);
      t.imem_err  = ($urandom_range(0, 49) == 0);
      t.dmem_err  = ($urandom_range(0, 19) == 0);
      t.ack_delay = ($urandom_range(0, 29) == 0) ? 20 : int'($urandom_range(0, 4));
      t.valc      = {$urandom, $urandom};
      t.valp      = {$urandom, $urandom};
      t.valm      = {$urandom, $urandom};
      model_run($sformatf("rnd%0d", n), t);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
